// File: rtl/pll_reconfig_sequencer.sv
// PLL reconfiguration sequencer: quiesces the hash cores, powers the PLL down,
// loads a new N/M divider pair, powers up, qualifies lock and retries on failure.
//
// Ports:
//   osc_clk   - sole clock
//   reset     - asynchronous active-high reset
//   cfg_valid - new divider request, held by the requester until accepted
//   cfg_n     - requested N divider
//   cfg_m     - requested M divider
//   cfg_ready - request accepted when cfg_valid && cfg_ready at the clock edge
//   pll_lock  - PLL lock indicator
//   pll_n     - PLL N divider (changes only while the PLL is powered down)
//   pll_m     - PLL M divider (changes only while the PLL is powered down)
//   pll_pdn   - 0 = PLL powered down, 1 = running
//   core_en   - hash-core enable
//   busy      - high in every state except RUN and FAULT
//   fault     - sticky lock failure, high only in FAULT
//   retry_cnt - failed lock attempts in the current sequence
//
// Build option:
//   PLL_LOCK_SYNC_EN - when defined, pll_lock passes through a 2-flop
//   synchronizer before the FSM sees it. When undefined, pll_lock is used
//   directly and must already be synchronous to osc_clk.
module pll_reconfig_sequencer #(
  parameter logic [7:0] N_DEFAULT     = 8'h10,
  parameter logic [7:0] M_DEFAULT     = 8'h01,
  parameter int         DRAIN_CYCLES  = 16,
  parameter int         PDN_CYCLES    = 32,
  parameter int         LOCK_TIMEOUT  = 4096,
  parameter int         SETTLE_CYCLES = 256,
  parameter int         MAX_RETRY     = 3
) (
  input  logic       osc_clk,
  input  logic       reset,
  input  logic       cfg_valid,
  input  logic [7:0] cfg_n,
  input  logic [7:0] cfg_m,
  output logic       cfg_ready,
  input  logic       pll_lock,
  output logic [7:0] pll_n,
  output logic [7:0] pll_m,
  output logic       pll_pdn,
  output logic       core_en,
  output logic       busy,
  output logic       fault,
  output logic [3:0] retry_cnt
);

  typedef enum logic [2:0] {
    S_PDN    = 3'd0,
    S_LOAD   = 3'd1,
    S_PWRUP  = 3'd2,
    S_SETTLE = 3'd3,
    S_FAIL   = 3'd4,
    S_RUN    = 3'd5,
    S_FAULT  = 3'd6,
    S_DRAIN  = 3'd7
  } state_t;

  // Counters are loaded with (count - 1) on entry and the state exits in
  // the cycle the counter reads zero, so each timed state lasts exactly
  // its parameter count.
  localparam logic [15:0] DRAIN_LD  = 16'(DRAIN_CYCLES - 1);
  localparam logic [15:0] PDN_LD    = 16'(PDN_CYCLES - 1);
  localparam logic [15:0] TMO_LD    = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] SETTLE_LD = 16'(SETTLE_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  shadow_n_q, shadow_n_d;
  logic [7:0]  shadow_m_q, shadow_m_d;
  logic [7:0]  pll_n_q, pll_n_d;
  logic [7:0]  pll_m_q, pll_m_d;
  logic        pll_pdn_q, pll_pdn_d;
  logic        core_en_q, core_en_d;
  logic        cfg_ready_q, cfg_ready_d;
  logic        busy_q, busy_d;
  logic        fault_q, fault_d;
  logic [3:0]  retry_q, retry_d;
  logic        lock_s;
  logic        accept;

`ifdef PLL_LOCK_SYNC_EN
  logic [1:0] lock_sync_q, lock_sync_d;

  always_comb begin
    lock_sync_d = {lock_sync_q[0], pll_lock};
  end

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      lock_sync_q <= 2'b00;
    end else begin
      lock_sync_q <= lock_sync_d;
    end
  end

  assign lock_s = lock_sync_q[1];
`else
  assign lock_s = pll_lock;
`endif

  // cfg_ready is only ever high in RUN or FAULT, so the handshake alone
  // identifies an acceptable request.
  assign accept = cfg_valid && cfg_ready_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q != 16'd0) ? cnt_q - 16'd1 : cnt_q;
    shadow_n_d = shadow_n_q;
    shadow_m_d = shadow_m_q;
    pll_n_d    = pll_n_q;
    pll_m_d    = pll_m_q;
    retry_d    = retry_q;

    unique case (state_q)
      S_DRAIN: begin
        if (cnt_q == 16'd0) begin
          state_d = S_PDN;
          cnt_d   = PDN_LD;
        end
      end
      S_PDN: begin
        if (cnt_q == 16'd0) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_PWRUP;
        cnt_d   = TMO_LD;
      end
      S_PWRUP: begin
        if (lock_s) begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LD;
        end else if (cnt_q == 16'd0) begin
          state_d = S_FAIL;
        end
      end
      S_SETTLE: begin
        if (!lock_s) begin
          state_d = S_FAIL;
        end else if (cnt_q == 16'd0) begin
          state_d = S_RUN;
        end
      end
      S_FAIL: begin
        if (retry_q == RETRY_MAX) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_PDN;
          cnt_d   = PDN_LD;
        end
      end
      S_RUN: begin
        // A new request and a lock loss both restart at DRAIN; the
        // request additionally replaces the shadow values.
        if (accept || !lock_s) begin
          state_d = S_DRAIN;
          cnt_d   = DRAIN_LD;
        end
      end
      S_FAULT: begin
        // Cores are already stopped, so skip the drain.
        if (accept) begin
          state_d = S_PDN;
          cnt_d   = PDN_LD;
        end
      end
    endcase

    if (accept) begin
      shadow_n_d = cfg_n;
      shadow_m_d = cfg_m;
      retry_d    = 4'd0;
    end

    // Dividers are written on LOAD entry, while pll_pdn is already low.
    if (state_d == S_LOAD && state_q != S_LOAD) begin
      pll_n_d = shadow_n_q;
      pll_m_d = shadow_m_q;
    end

    if (state_d == S_FAIL && state_q != S_FAIL) begin
      retry_d = (retry_q == 4'hf) ? retry_q : retry_q + 4'd1;
    end

    if (state_d == S_RUN) begin
      retry_d = 4'd0;
    end

    // Outputs are registered from the next state so they track the
    // state register cycle for cycle.
    pll_pdn_d   = (state_d == S_DRAIN) || (state_d == S_PWRUP) ||
                  (state_d == S_SETTLE) || (state_d == S_RUN);
    core_en_d   = (state_d == S_RUN);
    cfg_ready_d = (state_d == S_RUN) || (state_d == S_FAULT);
    busy_d      = !cfg_ready_d;
    fault_d     = (state_d == S_FAULT);
  end

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_PDN;
      cnt_q       <= PDN_LD;
      shadow_n_q  <= N_DEFAULT;
      shadow_m_q  <= M_DEFAULT;
      pll_n_q     <= N_DEFAULT;
      pll_m_q     <= M_DEFAULT;
      pll_pdn_q   <= 1'b0;
      core_en_q   <= 1'b0;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      fault_q     <= 1'b0;
      retry_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_n_q  <= shadow_n_d;
      shadow_m_q  <= shadow_m_d;
      pll_n_q     <= pll_n_d;
      pll_m_q     <= pll_m_d;
      pll_pdn_q   <= pll_pdn_d;
      core_en_q   <= core_en_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      fault_q     <= fault_d;
      retry_q     <= retry_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign pll_n     = pll_n_q;
  assign pll_m     = pll_m_q;
  assign pll_pdn   = pll_pdn_q;
  assign core_en   = core_en_q;
  assign busy      = busy_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;

endmodule
